// File: rtl/alu_pkg.sv
// Shared opcode, field, PSR and FSM definitions
// for the ALU issue sequencer.
package alu_pkg;

   localparam int DATA_W = 16;
   localparam int REG_N  = 16;

   localparam logic [4:0] OP_ADD    = 5'd0;
   localparam logic [4:0] OP_ADDU   = 5'd1;
   localparam logic [4:0] OP_ADDI   = 5'd2;
   localparam logic [4:0] OP_ADDUI  = 5'd3;
   localparam logic [4:0] OP_ADDC   = 5'd4;
   localparam logic [4:0] OP_ADDCU  = 5'd5;
   localparam logic [4:0] OP_ADDCUI = 5'd6;
   localparam logic [4:0] OP_ADDCI  = 5'd7;
   localparam logic [4:0] OP_SUB    = 5'd8;
   localparam logic [4:0] OP_SUBI   = 5'd9;
   localparam logic [4:0] OP_CMP    = 5'd10;
   localparam logic [4:0] OP_CMPU   = 5'd11;
   localparam logic [4:0] OP_CMPI   = 5'd12;
   localparam logic [4:0] OP_CMPUI  = 5'd13;
   localparam logic [4:0] OP_AND    = 5'd14;
   localparam logic [4:0] OP_OR     = 5'd15;
   localparam logic [4:0] OP_XOR    = 5'd16;
   localparam logic [4:0] OP_NOT    = 5'd17;
   localparam logic [4:0] OP_LSH    = 5'd18;
   localparam logic [4:0] OP_LSHI   = 5'd19;
   localparam logic [4:0] OP_RSH    = 5'd20;
   localparam logic [4:0] OP_RSHI   = 5'd21;
   localparam logic [4:0] OP_ALSH   = 5'd22;
   localparam logic [4:0] OP_ARSH   = 5'd23;
   localparam logic [4:0] OP_NOP    = 5'd24;

   localparam int PSR_C = 4;
   localparam int PSR_F = 3;
   localparam int PSR_L = 2;
   localparam int PSR_N = 1;
   localparam int PSR_Z = 0;

   localparam int F_OP_HI  = 15;
   localparam int F_OP_LO  = 11;
   localparam int F_RD_HI  = 10;
   localparam int F_RD_LO  = 7;
   localparam int F_RS_HI  = 6;
   localparam int F_RS_LO  = 3;
   localparam int F_IMM_HI = 6;
   localparam int F_IMM_LO = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_EXEC,
      ST_WB
   } state_t;

   localparam logic [31:0] LEGAL =
      ((32'd1 << 25) - 32'd1) & ~(32'd1 << OP_ADDCI);

   localparam logic [31:0] IS_IMM =
      (32'd1 << OP_ADDI)  | (32'd1 << OP_ADDUI) |
      (32'd1 << OP_ADDCUI)| (32'd1 << OP_SUBI)  |
      (32'd1 << OP_CMPI)  | (32'd1 << OP_CMPUI) |
      (32'd1 << OP_LSHI)  | (32'd1 << OP_RSHI);

   localparam logic [31:0] SIGN_EXT =
      (32'd1 << OP_ADDI) | (32'd1 << OP_SUBI) |
      (32'd1 << OP_CMPI);

   localparam logic [31:0] USES_CIN =
      (32'd1 << OP_ADDC) | (32'd1 << OP_ADDCU) |
      (32'd1 << OP_ADDCUI);

   localparam logic [31:0] CMP_OPS =
      (32'd1 << OP_CMP)  | (32'd1 << OP_CMPU) |
      (32'd1 << OP_CMPI) | (32'd1 << OP_CMPUI);

   localparam logic [31:0] WRITES_RD =
      LEGAL & ~CMP_OPS & ~(32'd1 << OP_NOP);

   localparam logic [31:0] MASK_FZ_OPS =
      (32'd1 << OP_ADD)  | (32'd1 << OP_ADDI) |
      (32'd1 << OP_ADDC) | (32'd1 << OP_SUB)  |
      (32'd1 << OP_SUBI);

   localparam logic [31:0] MASK_CZ_OPS =
      (32'd1 << OP_ADDU)  | (32'd1 << OP_ADDUI) |
      (32'd1 << OP_ADDCU) | (32'd1 << OP_ADDCUI);

   localparam logic [4:0] MASK_FZ = 5'b01001;
   localparam logic [4:0] MASK_CZ = 5'b10001;
   localparam logic [4:0] MASK_L  = 5'b00100;

   function automatic logic [4:0] flag_mask(
      input logic [4:0] op
   );
      logic [4:0] m;
      m = '0;
      unique case (1'b1)
         MASK_FZ_OPS[op]: m = MASK_FZ;
         MASK_CZ_OPS[op]: m = MASK_CZ;
         CMP_OPS[op]:     m = MASK_L;
         default:         m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// 16x16 register file: two decode read ports,
// one debug read port, one synchronous write port.
module alu_regfile
   import alu_pkg::*;
(
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [3:0]        ra_i,
   input  logic [3:0]        rb_i,
   input  logic [3:0]        dbg_addr_i,
   input  logic              we_i,
   input  logic [3:0]        wa_i,
   input  logic [DATA_W-1:0] wd_i,
   output logic [DATA_W-1:0] ra_data_o,
   output logic [DATA_W-1:0] rb_data_o,
   output logic [DATA_W-1:0] dbg_data_o
);

   logic [DATA_W-1:0] mem_q [REG_N];

   assign ra_data_o  = mem_q[ra_i];
   assign rb_data_o  = mem_q[rb_i];
   assign dbg_data_o = mem_q[dbg_addr_i];

   // Clear on reset, otherwise single-port write.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < REG_N; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[wa_i] <= wd_i;
      end
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Four-state sequencer feeding a combinational ALU:
// accept, read operands, execute, write back.
module alu_issue_ctrl
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_valid,
   input  logic [15:0] instr_word,
   output logic        instr_ready,
   output logic [7:0]  alu_op,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic        alu_cin,
   input  logic [15:0] alu_c,
   input  logic        alu_carry,
   input  logic        alu_flag,
   input  logic        alu_low,
   input  logic        alu_neg,
   input  logic        alu_zero,
   output logic [4:0]  psr,
   output logic        done,
   output logic        err,
   input  logic [3:0]  dbg_addr,
   output logic [15:0] dbg_data
);

   state_t      state_q, state_d;
   logic [15:0] ir_q, ir_d;
   logic [7:0]  op_q, op_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic        cin_q, cin_d;
   logic [15:0] res_q, res_d;
   logic [4:0]  flg_q, flg_d;
   logic [4:0]  psr_q, psr_d;

   logic        we;
   logic        ready;
   logic        done_p;
   logic        err_p;

   logic [4:0]  op5;
   logic [3:0]  rd;
   logic [3:0]  rs;
   logic [6:0]  imm7;
   logic        legal;
   logic [15:0] imm_ext;
   logic [15:0] rd_data;
   logic [15:0] rs_data;
   logic [4:0]  mask;

   assign op5   = ir_q[F_OP_HI:F_OP_LO];
   assign rd    = ir_q[F_RD_HI:F_RD_LO];
   assign rs    = ir_q[F_RS_HI:F_RS_LO];
   assign imm7  = ir_q[F_IMM_HI:F_IMM_LO];
   assign legal = LEGAL[op5];
   assign mask  = flag_mask(op5);

   assign imm_ext = SIGN_EXT[op5]
                  ? {{9{imm7[6]}}, imm7}
                  : {9'd0, imm7};

   alu_regfile u_rf (
      .clk_i      (clk),
      .reset_i    (reset),
      .ra_i       (rd),
      .rb_i       (rs),
      .dbg_addr_i (dbg_addr),
      .we_i       (we),
      .wa_i       (rd),
      .wd_i       (res_q),
      .ra_data_o  (rd_data),
      .rb_data_o  (rs_data),
      .dbg_data_o (dbg_data)
   );

   // Next-state, decode, capture and retire logic.
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      cin_d   = cin_q;
      res_d   = res_q;
      flg_d   = flg_q;
      psr_d   = psr_q;
      we      = 1'b0;
      ready   = 1'b0;
      done_p  = 1'b0;
      err_p   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ready = 1'b1;
            if (instr_valid) begin
               ir_d    = instr_word;
               state_d = ST_READ;
            end
         end
         ST_READ: begin
            state_d = ST_EXEC;
            if (legal) begin
               op_d = {3'b000, op5};
               a_d  = rd_data;
               if (op5 == OP_NOT) begin
                  b_d = '0;
               end else if (IS_IMM[op5]) begin
                  b_d = imm_ext;
               end else begin
                  b_d = rs_data;
               end
               cin_d = USES_CIN[op5] & psr_q[PSR_C];
            end else begin
               op_d  = {3'b000, OP_NOP};
               a_d   = '0;
               b_d   = '0;
               cin_d = 1'b0;
            end
         end
         ST_EXEC: begin
            state_d = ST_WB;
            res_d   = alu_c;
            flg_d   = {alu_carry, alu_flag,
                       alu_low, alu_neg, alu_zero};
         end
         ST_WB: begin
            state_d = ST_IDLE;
            op_d    = {3'b000, OP_NOP};
            cin_d   = 1'b0;
            if (legal) begin
               done_p = 1'b1;
               we     = WRITES_RD[op5];
               psr_d  = (psr_q & ~mask) | (flg_q & mask);
            end else begin
               err_p = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ir_q    <= '0;
         op_q    <= {3'b000, OP_NOP};
         a_q     <= '0;
         b_q     <= '0;
         cin_q   <= 1'b0;
         res_q   <= '0;
         flg_q   <= '0;
         psr_q   <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cin_q   <= cin_d;
         res_q   <= res_d;
         flg_q   <= flg_d;
         psr_q   <= psr_d;
      end
   end

   assign instr_ready = ready;
   assign alu_op      = op_q;
   assign alu_a       = a_q;
   assign alu_b       = b_q;
   assign alu_cin     = cin_q;
   assign psr         = psr_q;
   assign done        = done_p;
   assign err         = err_p;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small
// behavioural ALU on the result side.
module tb_alu_issue_ctrl;

   logic        clk;
   logic        reset;
   logic        instr_valid;
   logic [15:0] instr_word;
   logic        instr_ready;
   logic [7:0]  alu_op;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic        alu_cin;
   logic [15:0] alu_c;
   logic        alu_carry;
   logic        alu_flag;
   logic        alu_low;
   logic        alu_neg;
   logic        alu_zero;
   logic [4:0]  psr;
   logic        done;
   logic        err;
   logic [3:0]  dbg_addr;
   logic [15:0] dbg_data;

   int ncmp;
   int nfail;
   int cyc;
   int done_cnt;

   typedef struct {
      logic [15:0] word;
      logic [3:0]  rg;
      logic [15:0] val;
      logic [4:0]  psr;
      logic        err;
      logic [7:0]  op;
      logic        cin;
   } vec_t;

   vec_t vt[21];

   alu_issue_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .instr_valid (instr_valid),
      .instr_word  (instr_word),
      .instr_ready (instr_ready),
      .alu_op      (alu_op),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_cin     (alu_cin),
      .alu_c       (alu_c),
      .alu_carry   (alu_carry),
      .alu_flag    (alu_flag),
      .alu_low     (alu_low),
      .alu_neg     (alu_neg),
      .alu_zero    (alu_zero),
      .psr         (psr),
      .done        (done),
      .err         (err),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
   end

   // Behavioural ALU.
   logic [16:0] s17;
   always_comb begin
      s17       = '0;
      alu_c     = '0;
      alu_carry = 1'b0;
      alu_flag  = 1'b0;
      alu_low   = 1'b0;
      case (alu_op)
         8'd0, 8'd1, 8'd2, 8'd3,
         8'd4, 8'd5, 8'd6: begin
            s17 = {1'b0, alu_a} + {1'b0, alu_b}
                + {16'd0, alu_cin};
            alu_c     = s17[15:0];
            alu_carry = s17[16];
            alu_flag  = (alu_a[15] == alu_b[15])
                     && (s17[15] != alu_a[15]);
         end
         8'd8, 8'd9: begin
            s17 = {1'b0, alu_a} - {1'b0, alu_b};
            alu_c     = s17[15:0];
            alu_carry = s17[16];
            alu_flag  = (alu_a[15] != alu_b[15])
                     && (s17[15] != alu_a[15]);
         end
         8'd10, 8'd12: begin
            alu_c   = alu_a - alu_b;
            alu_low = $signed(alu_a) < $signed(alu_b);
         end
         8'd11, 8'd13: begin
            alu_c   = alu_a - alu_b;
            alu_low = alu_a < alu_b;
         end
         8'd14: alu_c = alu_a & alu_b;
         8'd15: alu_c = alu_a | alu_b;
         8'd16: alu_c = alu_a ^ alu_b;
         8'd17: alu_c = ~alu_a;
         8'd18, 8'd19: alu_c = alu_a << alu_b[3:0];
         8'd20, 8'd21: alu_c = alu_a >> alu_b[3:0];
         default: alu_c = '0;
      endcase
   end
   assign alu_zero = (alu_c == 16'd0);
   assign alu_neg  = alu_c[15];

   function automatic logic [15:0] ri(
      input logic [4:0] op, input logic [3:0] rd,
      input logic [6:0] imm
   );
      return {op, rd, imm};
   endfunction

   function automatic logic [15:0] rr(
      input logic [4:0] op, input logic [3:0] rd,
      input logic [3:0] rs
   );
      return {op, rd, rs, 3'b000};
   endfunction

   task automatic chk(
      input string nm, input int idx,
      input logic [15:0] act, input logic [15:0] exp
   );
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s[%0d]: got %h want %h",
                  nm, idx, act, exp);
      end
   endtask

   // Caller is aligned just after a rising edge.
   task automatic issue(input int idx, input vec_t v);
      int n;
      instr_word  = v.word;
      instr_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("accept", idx, 16'(instr_ready), 16'd1);
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      @(negedge clk);
      chk("pulse_t1", idx, {14'd0, done, err}, 16'd0);
      chk("ready_t1", idx, 16'(instr_ready), 16'd0);
      @(negedge clk);
      chk("pulse_t2", idx, {14'd0, done, err}, 16'd0);
      chk("op_exec", idx, 16'(alu_op), 16'(v.op));
      chk("cin_exec", idx, 16'(alu_cin), 16'(v.cin));
      @(negedge clk);
      chk("done_t3", idx, 16'(done), 16'(!v.err));
      chk("err_t3", idx, 16'(err), 16'(v.err));
      chk("op_wb", idx, 16'(alu_op), 16'(v.op));
      @(negedge clk);
      chk("ready_t4", idx, 16'(instr_ready), 16'd1);
      chk("pulse_t4", idx, {14'd0, done, err}, 16'd0);
      dbg_addr = v.rg;
      #1;
      chk("reg", idx, dbg_data, v.val);
      chk("psr", idx, 16'(psr), 16'(v.psr));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit");
      $fatal(1);
   end

   initial begin
      int st[3];
      int got;
      int n;
      int d0;

      ncmp = 0;
      nfail = 0;
      cyc = 0;
      done_cnt = 0;
      reset = 1'b1;
      instr_valid = 1'b0;
      instr_word = '0;
      dbg_addr = '0;

      vt[0]  = '{ri(2, 1, 7'h05),  1, 16'h0005, 5'h00, 0, 8'd2,  0};
      vt[1]  = '{ri(2, 1, 7'h7F),  1, 16'h0004, 5'h00, 0, 8'd2,  0};
      vt[2]  = '{ri(2, 2, 7'h7F),  2, 16'hFFFF, 5'h00, 0, 8'd2,  0};
      vt[3]  = '{ri(3, 2, 7'h01),  2, 16'h0000, 5'h11, 0, 8'd3,  0};
      vt[4]  = '{rr(5, 3, 0),      3, 16'h0001, 5'h00, 0, 8'd5,  1};
      vt[5]  = '{ri(12, 1, 7'h05), 1, 16'h0004, 5'h04, 0, 8'd12, 0};
      vt[6]  = '{ri(12, 1, 7'h03), 1, 16'h0004, 5'h00, 0, 8'd12, 0};
      vt[7]  = '{ri(7, 1, 7'h01),  1, 16'h0004, 5'h00, 1, 8'd24, 0};
      vt[8]  = '{ri(30, 1, 7'h7F), 1, 16'h0004, 5'h00, 1, 8'd24, 0};
      vt[9]  = '{ri(9, 4, 7'h7E),  4, 16'h0002, 5'h00, 0, 8'd9,  0};
      vt[10] = '{rr(8, 4, 4),      4, 16'h0000, 5'h01, 0, 8'd8,  0};
      vt[11] = '{ri(3, 6, 7'h7F),  6, 16'h007F, 5'h00, 0, 8'd3,  0};
      vt[12] = '{ri(19, 6, 7'h08), 6, 16'h7F00, 5'h00, 0, 8'd19, 0};
      vt[13] = '{rr(15, 6, 1),     6, 16'h7F04, 5'h00, 0, 8'd15, 0};
      vt[14] = '{rr(0, 6, 6),      6, 16'hFE08, 5'h08, 0, 8'd0,  0};
      vt[15] = '{rr(17, 7, 6),     7, 16'hFFFF, 5'h08, 0, 8'd17, 0};
      vt[16] = '{rr(10, 7, 1),     7, 16'hFFFF, 5'h0C, 0, 8'd10, 0};
      vt[17] = '{rr(11, 7, 1),     7, 16'hFFFF, 5'h08, 0, 8'd11, 0};
      vt[18] = '{ri(21, 7, 7'h04), 7, 16'h0FFF, 5'h08, 0, 8'd21, 0};
      vt[19] = '{ri(24, 0, 7'h00), 7, 16'h0FFF, 5'h08, 0, 8'd24, 0};
      vt[20] = '{rr(4, 8, 7),      8, 16'h0FFF, 5'h00, 0, 8'd4,  0};

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_ready", 0, 16'(instr_ready), 16'd1);
      chk("rst_psr", 0, 16'(psr), 16'd0);
      chk("rst_op", 0, 16'(alu_op), 16'd24);
      chk("rst_a", 0, alu_a, 16'd0);
      chk("rst_b", 0, alu_b, 16'd0);
      chk("rst_cin", 0, 16'(alu_cin), 16'd0);
      chk("rst_pulse", 0, {14'd0, done, err}, 16'd0);
      for (int i = 0; i < 16; i++) begin
         dbg_addr = 4'(i);
         #1;
         chk("rst_reg", i, dbg_data, 16'd0);
      end
      @(posedge clk);
      #1;

      // Table-driven instruction sequence.
      for (int i = 0; i < 21; i++) begin
         issue(i, vt[i]);
      end

      // Valid held high across three instructions.
      d0 = done_cnt;
      got = 0;
      n = 0;
      instr_word = ri(2, 9, 7'h01);
      instr_valid = 1'b1;
      while (got < 3 && n < 40) begin
         @(negedge clk);
         n++;
         if (instr_ready) begin
            st[got] = cyc;
            got++;
            if (got == 3) begin
               @(posedge clk);
               #1;
               instr_valid = 1'b0;
            end
         end
      end
      instr_valid = 1'b0;
      chk("hs_count", 0, 16'(got), 16'd3);
      if (got == 3) begin
         chk("hs_gap", 0, 16'(st[1] - st[0]), 16'd4);
         chk("hs_gap", 1, 16'(st[2] - st[1]), 16'd4);
      end
      repeat (6) @(negedge clk);
      #1;
      dbg_addr = 4'd9;
      #1;
      chk("hs_r9", 0, dbg_data, 16'd3);
      chk("hs_done", 0, 16'(done_cnt - d0), 16'd3);
      @(posedge clk);
      #1;

      // Reset during EXEC aborts the instruction.
      instr_word = ri(2, 5, 7'h09);
      instr_valid = 1'b1;
      @(negedge clk);
      chk("ab_ready", 0, 16'(instr_ready), 16'd1);
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      d0 = done_cnt;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("ab_ready", 1, 16'(instr_ready), 16'd1);
      chk("ab_op", 0, 16'(alu_op), 16'd24);
      chk("ab_a", 0, alu_a, 16'd0);
      chk("ab_b", 0, alu_b, 16'd0);
      chk("ab_cin", 0, 16'(alu_cin), 16'd0);
      chk("ab_psr", 0, 16'(psr), 16'd0);
      chk("ab_pulse", 0, {14'd0, done, err}, 16'd0);
      repeat (5) @(negedge clk);
      #1;
      chk("ab_done", 0, 16'(done_cnt - d0), 16'd0);
      dbg_addr = 4'd5;
      #1;
      chk("ab_r5", 0, dbg_data, 16'd0);
      dbg_addr = 4'd9;
      #1;
      chk("ab_r9", 0, dbg_data, 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncmp, nfail);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Instruction sequencer that drives the 16-bit ALU from the controlling side. It accepts 16-bit instruction words over a valid/ready handshake and decodes each into an 8-bit ALU opcode plus A/B operands. Operands come from a 16×16 register file, or from a sign- or zero-extended immediate. It then captures the ALU result and flags, writes the result back, and updates a 5-bit PSR. It sits between the instruction source (bench or future fetch unit) and the combinational ALU.

## Interface
- (no parameters; widths fixed: data 16, opcode 8, registers 16)
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- instr_valid  in  1  instr_word is valid
- instr_word  in  16  instruction
- instr_ready  out  1  block can accept an instruction
- alu_op  out  8  ALU opcode
- alu_a  out  16  ALU operand A
- alu_b  out  16  ALU operand B
- alu_cin  out  1  carry-in for ADDC-family (PSR.C)
- alu_c  in  16  ALU result
- alu_carry, alu_flag, alu_low, alu_neg, alu_zero  in  1 each  ALU flags
- psr  out  5  {C,F,L,N,Z} = bits [4:0]
- done  out  1  one-cycle pulse; instruction retired
- err  out  1  one-cycle pulse; illegal opcode retired
- dbg_addr  in  4  debug register select
- dbg_data  out  16  combinational read of register dbg_addr

## Operation
- Instruction format:
  - [15:11] op5; ALU opcode = {3'b0, op5}.
  - [10:7] rd.
  - Register forms: [6:3] rs; [2:0] ignored.
  - Immediate forms: [6:0] imm7.
- Immediate extension:
  - Sign-extended: ADDI(2), SUBI(9), CMPI(12).
  - Zero-extended: ADDUI(3), ADDCUI(6), CMPUI(13), LSHI(19), RSHI(21).
- Operands:
  - alu_a = R[rd].
  - alu_b = R[rs] for register forms, ext(imm7) for immediate forms.
  - NOT uses A only.
- Legal op5: 0–6 and 8–24. Illegal: 7 (ADDCI, reserved) and 25–31.
- Write-back of R[rd] ← alu_c: all legal ops except CMP/CMPU/CMPI/CMPUI (10–13) and NOP (24).
- PSR update masks:
  - ADD/ADDI/ADDC/SUB/SUBI: F, Z.
  - ADDU/ADDUI/ADDCU/ADDCUI: C, Z.
  - CMP family: L.
  - Logic, shift, NOP: none.
  - Bits outside the mask hold their value.
- alu_cin = PSR.C whenever op5 ∈ {4,5,6}, else 0.
- FSM (one-hot or encoded, sequenced as follows):
  - IDLE: instr_ready=1; on instr_valid, latch the word and go to READ.
  - READ: decode; register alu_op/alu_a/alu_b; go to EXEC.
  - EXEC: outputs stable; at the clock edge, capture alu_c and the flags; go to WB.
  - WB: write R[rd] and PSR; pulse done (legal) or err (illegal); go to IDLE.
- Illegal op: decode to NOP (alu_op=24); no register or PSR change; err pulses in WB.

## Timing
- Accept edge = T0. READ = T0+1, EXEC = T0+2, WB = T0+3.
- done/err high during T0+3 only. Register and PSR values are visible from T0+4.
- Throughput: one instruction per 4 clocks. instr_ready is low in READ, EXEC and WB.
- instr_valid while not ready: ignored; the word must be held by the source. Never double-accepted.
- alu_op/alu_a/alu_b change only on the READ→EXEC edge and are held through WB.
- Idle alu_op = 24 (NOP).
- Reset values (next edge): state IDLE, instr_ready 1, all R = 0, psr 0, alu_op 24, alu_a/alu_b 0, alu_cin 0, done/err 0.
- Reset in any state aborts the instruction. No write-back, no done.
- rd == rs: the read occurs in READ, before the write in WB; no hazard.
- dbg_data reflects a write from T0+4.

## Structure
- Shared package alu_pkg:
  - The 25 opcode constants 0–24 (ADD…NOP).
  - PSR bit indices.
  - Instruction field positions.
  - FSM state type.
  - Per-opcode is_imm, sign_ext, writes_rd and flag-mask constants.
- One sub-module, alu_regfile:
  - 16×16 flops.
  - Two combinational read ports (rd and rs) plus a dbg read port.
  - One synchronous write port.
  - Synchronous reset to zero.

## Test plan
- **Reset:** assert reset 2 cycles → instr_ready=1, psr=0, dbg_data=0 for all 16 addresses, alu_op=24.
- **Signed immediates:** ADDI r1,#5 then ADDI r1,#0x7F (−1) → r1=4. done exactly 3 cycles after each accept. psr.Z=0, psr.F=0.
- **Unsigned carry:** ADDI r2,#0x7F (r2=0xFFFF), then ADDUI r2,#1 → r2=0x0000, psr.C=1, psr.Z=1. ADDCU r3,r0 → r3=1 (alu_cin=1).
- **Compare:** with r1=4, CMPI r1,#5 → psr.L=1, r1 still 4, psr.C/Z unchanged. CMPI r1,#3 → L=0.
- **Illegal ops:** instruction words with op5=7 and op5=30 → err pulse at T0+3, no done, no register or PSR change, instr_ready back at T0+4.
- **Handshake and reset abort:**
  - Hold instr_valid high across 3 instructions → exactly 3 accepts, 4 clocks apart.
  - Assert reset during EXEC of ADDI r5,#9 → r5 stays 0, no done, all outputs at reset values.
